// File: rtl/pong_pkg.sv
// Shared types, default geometry and width helpers for the pong ball engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  // Default geometry and gameplay constants for a 640x480 screen.
  localparam int PONG_H_RES       = 640;
  localparam int PONG_V_RES       = 480;
  localparam int PONG_BALL_SIZE   = 8;
  localparam int PONG_PADDLE_W    = 8;
  localparam int PONG_PADDLE_H    = 64;
  localparam int PONG_PADDLE_X    = 16;
  localparam int PONG_SPEED_X     = 4;
  localparam int PONG_SPEED_Y     = 2;
  localparam int PONG_SERVE_DELAY = 60;
  localparam int PONG_WIN_SCORE   = 9;
  localparam int PONG_SCORE_W     = 4;

  // Coordinate widths derived from the screen size.
  function automatic int pong_xw(input int h_res);
    return $clog2(h_res);
  endfunction

  function automatic int pong_yw(input int v_res);
    return $clog2(v_res);
  endfunction

endpackage

// File: rtl/pong_paddle_hit.sv
// Paddle contact check: ball's next x has reached the paddle face and the ball
// overlaps the paddle vertically at its current y. Latency: combinational.
// Backpressure: none.
//
// Ports:
//   nx       next ball left x, signed, XW+2 bits
//   ball_y   current ball top y
//   paddle_y paddle top y (unclamped)
//   hit      contact and overlap both true
module pong_paddle_hit #(
  parameter int XW        = 10,
  parameter int YW        = 9,
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_H  = 64,
  parameter int IS_RIGHT  = 0,
  // Left side: largest nx that touches the paddle face.
  // Right side: smallest nx that touches the paddle face.
  parameter int EDGE      = 24
) (
  input  logic signed [XW+1:0] nx,
  input  logic        [YW-1:0] ball_y,
  input  logic        [YW-1:0] paddle_y,
  output logic                 hit
);

  localparam logic signed [XW+1:0] EDGE_S = (XW+2)'(EDGE);
  localparam logic        [YW+1:0] BS     = (YW+2)'(BALL_SIZE);
  localparam logic        [YW+1:0] PH     = (YW+2)'(PADDLE_H);

  logic [YW+1:0] by;
  logic [YW+1:0] py;
  logic          contact;
  logic          overlap;

  // Two spare bits keep paddle_y + PADDLE_H from wrapping for any paddle input.
  assign by      = {2'b00, ball_y};
  assign py      = {2'b00, paddle_y};
  assign overlap = ((by + BS) > py) && (by < (py + PH));
  assign contact = (IS_RIGHT != 0) ? (nx >= EDGE_S) : (nx <= EDGE_S);
  assign hit     = contact && overlap;

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball/score engine: moves the ball per frame tick, bounces, scores, serves.
// Latency: one cycle from a frame_tick/serve cycle to the updated outputs.
// Backpressure: none; frame_tick and serve are sampled every cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   frame_tick          one-cycle pulse per frame
//   serve               start/restart request (level)
//   paddle_l_y/_r_y     paddle top y positions
//   ball_x, ball_y      registered ball top-left position
//   score_l, score_r    registered scores
//   point_l, point_r    one-cycle goal pulses
//   game_over, playing  registered state flags
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int H_RES       = PONG_H_RES,
  parameter int V_RES       = PONG_V_RES,
  parameter int BALL_SIZE   = PONG_BALL_SIZE,
  parameter int PADDLE_W    = PONG_PADDLE_W,
  parameter int PADDLE_H    = PONG_PADDLE_H,
  parameter int PADDLE_X    = PONG_PADDLE_X,
  parameter int SPEED_X     = PONG_SPEED_X,
  parameter int SPEED_Y     = PONG_SPEED_Y,
  parameter int SERVE_DELAY = PONG_SERVE_DELAY,
  parameter int WIN_SCORE   = PONG_WIN_SCORE,
  parameter int SCORE_W     = PONG_SCORE_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_tick,
  input  logic                        serve,
  input  logic [pong_yw(V_RES)-1:0]   paddle_l_y,
  input  logic [pong_yw(V_RES)-1:0]   paddle_r_y,
  output logic [pong_xw(H_RES)-1:0]   ball_x,
  output logic [pong_yw(V_RES)-1:0]   ball_y,
  output logic [SCORE_W-1:0]          score_l,
  output logic [SCORE_W-1:0]          score_r,
  output logic                        point_l,
  output logic                        point_r,
  output logic                        game_over,
  output logic                        playing
);

  localparam int XW  = pong_xw(H_RES);
  localparam int YW  = pong_yw(V_RES);
  localparam int DW  = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam int RPX = H_RES - PADDLE_X - PADDLE_W;

  localparam logic [XW-1:0]        X_CTR    = XW'((H_RES - BALL_SIZE) / 2);
  localparam logic [YW-1:0]        Y_CTR    = YW'((V_RES - BALL_SIZE) / 2);
  localparam logic [XW-1:0]        X_LP     = XW'(PADDLE_X + PADDLE_W);
  localparam logic [XW-1:0]        X_RP     = XW'(RPX - BALL_SIZE);
  localparam logic [YW-1:0]        Y_MAX    = YW'(V_RES - BALL_SIZE);
  localparam logic signed [XW+1:0] SX_ZERO  = '0;
  localparam logic signed [XW+1:0] SX_GOAL  = (XW+2)'(H_RES - BALL_SIZE);
  localparam logic signed [XW+1:0] SPX_P    = (XW+2)'(SPEED_X);
  localparam logic signed [XW+1:0] SPX_N    = (XW+2)'(-SPEED_X);
  localparam logic signed [YW+1:0] SY_ZERO  = '0;
  localparam logic signed [YW+1:0] SY_MAX   = (YW+2)'(V_RES - BALL_SIZE);
  localparam logic signed [YW+1:0] SPY_P    = (YW+2)'(SPEED_Y);
  localparam logic signed [YW+1:0] SPY_N    = (YW+2)'(-SPEED_Y);
  localparam logic [SCORE_W-1:0]   WIN      = SCORE_W'(WIN_SCORE);
  localparam logic [DW-1:0]        DLY_LAST = DW'(SERVE_DELAY - 1);

  state_t                 state;
  logic signed [XW+1:0]   dx;
  logic signed [YW+1:0]   dy;
  logic        [DW-1:0]   delay_cnt;

  logic signed [XW+1:0]   nx;
  logic signed [YW+1:0]   ny;
  logic        [XW-1:0]   x_next;
  logic        [YW-1:0]   y_next;
  logic signed [XW+1:0]   dx_next;
  logic signed [YW+1:0]   dy_next;
  logic                   hit_l;
  logic                   hit_r;
  logic                   goal_l;
  logic                   goal_r;
  logic [SCORE_W-1:0]     score_l_inc;
  logic [SCORE_W-1:0]     score_r_inc;

  assign nx          = $signed({2'b00, ball_x}) + dx;
  assign ny          = $signed({2'b00, ball_y}) + dy;
  assign score_l_inc = score_l + SCORE_W'(1);
  assign score_r_inc = score_r + SCORE_W'(1);

  pong_paddle_hit #(
    .XW(XW), .YW(YW), .BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H),
    .IS_RIGHT(0), .EDGE(PADDLE_X + PADDLE_W)
  ) u_hit_l (
    .nx(nx), .ball_y(ball_y), .paddle_y(paddle_l_y), .hit(hit_l)
  );

  pong_paddle_hit #(
    .XW(XW), .YW(YW), .BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H),
    .IS_RIGHT(1), .EDGE(RPX - BALL_SIZE)
  ) u_hit_r (
    .nx(nx), .ball_y(ball_y), .paddle_y(paddle_r_y), .hit(hit_r)
  );

  // Wall bounce: clamp to the wall and force the vertical direction away from it.
  always_comb begin
    y_next  = ball_y;
    dy_next = dy;
    if (ny <= SY_ZERO) begin
      y_next  = '0;
      dy_next = SPY_P;
    end else if (ny >= SY_MAX) begin
      y_next  = Y_MAX;
      dy_next = SPY_N;
    end else begin
      y_next  = ny[YW-1:0];
    end
  end

  // Horizontal: only the side the ball is heading toward is examined, and a
  // paddle contact wins over a goal on the same tick.
  always_comb begin
    x_next  = ball_x;
    dx_next = dx;
    goal_l  = 1'b0;
    goal_r  = 1'b0;
    if (dx[XW+1]) begin
      if (hit_l) begin
        x_next  = X_LP;
        dx_next = SPX_P;
      end else if (nx <= SX_ZERO) begin
        goal_r  = 1'b1;
      end else begin
        x_next  = nx[XW-1:0];
      end
    end else begin
      if (hit_r) begin
        x_next  = X_RP;
        dx_next = SPX_N;
      end else if (nx >= SX_GOAL) begin
        goal_l  = 1'b1;
      end else begin
        x_next  = nx[XW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ball_x    <= X_CTR;
      ball_y    <= Y_CTR;
      dx        <= SPX_P;
      dy        <= SPY_P;
      delay_cnt <= '0;
      score_l   <= '0;
      score_r   <= '0;
      point_l   <= 1'b0;
      point_r   <= 1'b0;
      game_over <= 1'b0;
      playing   <= 1'b0;
    end else begin
      point_l <= 1'b0;
      point_r <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (serve) begin
            state   <= ST_PLAY;
            playing <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (frame_tick) begin
            if (goal_l || goal_r) begin
              // Ball and direction stay frozen; dx keeps pointing at the
              // side that conceded, which is where the re-serve goes.
              playing <= 1'b0;
              if (goal_l) begin
                score_l <= score_l_inc;
                point_l <= 1'b1;
              end else begin
                score_r <= score_r_inc;
                point_r <= 1'b1;
              end
              if ((goal_l && score_l_inc == WIN) || (goal_r && score_r_inc == WIN)) begin
                state     <= ST_OVER;
                game_over <= 1'b1;
              end else begin
                state     <= ST_SCORED;
                delay_cnt <= '0;
              end
            end else begin
              ball_x <= x_next;
              ball_y <= y_next;
              dx     <= dx_next;
              dy     <= dy_next;
            end
          end
        end
        ST_SCORED: begin
          if (frame_tick) begin
            if (delay_cnt == DLY_LAST) begin
              state   <= ST_PLAY;
              playing <= 1'b1;
              ball_x  <= X_CTR;
              ball_y  <= Y_CTR;
              dy      <= SPY_P;
              dx      <= dx[XW+1] ? SPX_N : SPX_P;
            end else begin
              delay_cnt <= delay_cnt + DW'(1);
            end
          end
        end
        ST_OVER: begin
          if (serve) begin
            state     <= ST_PLAY;
            playing   <= 1'b1;
            game_over <= 1'b0;
            score_l   <= '0;
            score_r   <= '0;
            ball_x    <= X_CTR;
            ball_y    <= Y_CTR;
            dx        <= SPX_P;
            dy        <= SPY_P;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_ball_engine.sv
module tb_pong_ball_engine;

  // Default geometry
  localparam int XC   = 316;
  localparam int YC   = 236;
  localparam int SX   = 4;
  localparam int SY   = 2;
  localparam int LPE  = 24;     // left paddle face
  localparam int RPX  = 616;    // right paddle face
  localparam int YMAX = 472;
  localparam int M_IDLE = 0, M_PLAY = 1, M_SCORED = 2, M_OVER = 3;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       serve;
  logic [8:0] paddle_l_y;
  logic [8:0] paddle_r_y;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       point_l;
  logic       point_r;
  logic       game_over;
  logic       playing;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_mode, m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_cnt;
  int m_pl, m_pr;
  bit m_left_scored;

  pong_ball_engine dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .serve(serve),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .ball_x(ball_x), .ball_y(ball_y), .score_l(score_l), .score_r(score_r),
    .point_l(point_l), .point_r(point_r), .game_over(game_over), .playing(playing)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit overlaps(input int y, input int py);
    return (y + 8 > py) && (y < py + 64);
  endfunction

  task automatic model_centre();
    m_x = XC;
    m_y = YC;
    m_dy = SY;
  endtask

  // One clock edge of game behaviour, in plain integer geometry.
  task automatic model_step();
    int nx, ny, new_x, new_dx;
    bit gl, gr;
    m_pl = 0;
    m_pr = 0;
    if (reset) begin
      m_mode = M_IDLE; model_centre(); m_dx = SX;
      m_sl = 0; m_sr = 0; m_cnt = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (serve) m_mode = M_PLAY;
      M_PLAY: if (frame_tick) begin
        nx = m_x + m_dx;
        ny = m_y + m_dy;
        gl = 0; gr = 0;
        new_x = nx; new_dx = m_dx;
        if (m_dx < 0) begin
          if (nx <= LPE && overlaps(m_y, int'(paddle_l_y))) begin
            new_x = LPE; new_dx = SX;
          end else if (nx <= 0) gr = 1;
        end else begin
          if (nx + 8 >= RPX && overlaps(m_y, int'(paddle_r_y))) begin
            new_x = RPX - 8; new_dx = -SX;
          end else if (nx + 8 >= 640) gl = 1;
        end
        if (gl || gr) begin
          m_left_scored = gl;
          if (gl) begin m_sl++; m_pl = 1; end
          else    begin m_sr++; m_pr = 1; end
          if (m_sl == 9 || m_sr == 9) m_mode = M_OVER;
          else begin m_mode = M_SCORED; m_cnt = 0; end
        end else begin
          m_x = new_x; m_dx = new_dx;
          if (ny <= 0)         begin m_y = 0;    m_dy = SY;  end
          else if (ny >= YMAX) begin m_y = YMAX; m_dy = -SY; end
          else m_y = ny;
        end
      end
      M_SCORED: if (frame_tick) begin
        m_cnt++;
        if (m_cnt == 60) begin
          model_centre();
          m_dx = m_left_scored ? SX : -SX;  // toward the conceding player
          m_mode = M_PLAY;
        end
      end
      default: if (serve) begin
        m_sl = 0; m_sr = 0;
        model_centre(); m_dx = SX;
        m_mode = M_PLAY;
      end
    endcase
  endtask

  // Every cycle: advance the model on the edge, compare just after it.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("ball_x",    int'(ball_x),    m_x);
      chk("ball_y",    int'(ball_y),    m_y);
      chk("score_l",   int'(score_l),   m_sl);
      chk("score_r",   int'(score_r),   m_sr);
      chk("point_l",   int'(point_l),   m_pl);
      chk("point_r",   int'(point_r),   m_pr);
      chk("playing",   int'(playing),   int'(m_mode == M_PLAY));
      chk("game_over", int'(game_over), int'(m_mode == M_OVER));
    end
  end

  task automatic do_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic pulse_serve();
    serve = 1'b1;
    @(negedge clk);
    serve = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"},    int'(ball_x), XC);
    chk({tag, "_y"},    int'(ball_y), YC);
    chk({tag, "_sl"},   int'(score_l), 0);
    chk({tag, "_sr"},   int'(score_r), 0);
    chk({tag, "_pt"},   int'(point_l | point_r), 0);
    chk({tag, "_flag"}, int'(playing | game_over), 0);
  endtask

  // Serve from centre toward a right paddle at y=0: left goal on tick 79.
  task automatic left_goal(input string tag);
    ticks(78);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk({tag, "_point_l"}, int'(point_l), 1);
    chk({tag, "_frz_x"}, int'(ball_x), 628);
    chk({tag, "_frz_y"}, int'(ball_y), 392);
    @(negedge clk);
    chk({tag, "_point_l_drop"}, int'(point_l), 0);
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; serve = 1'b0;
    paddle_l_y = '0; paddle_r_y = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: idle ticks do nothing; serve with a simultaneous tick does not move
    chk_reset_vals("rst");
    ticks(10);
    chk_reset_vals("idle");
    serve = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    serve = 1'b0; frame_tick = 1'b0;
    chk("serve_x", int'(ball_x), XC);
    chk("serve_playing", int'(playing), 1);

    // 2: first move
    do_tick();
    chk("move1_x", int'(ball_x), 320);
    chk("move1_y", int'(ball_y), 238);

    // 3: right paddle bounce
    pulse_reset();
    paddle_r_y = 9'd350;
    pulse_serve();
    ticks(73);
    chk("rbounce_x", int'(ball_x), 608);
    chk("rbounce_y", int'(ball_y), 382);
    do_tick();
    chk("after_bounce_x", int'(ball_x), 604);
    chk("after_bounce_y", int'(ball_y), 384);

    // 4: left goal, serve delay, re-serve to the right
    pulse_reset();
    paddle_r_y = 9'd0;
    pulse_serve();
    left_goal("g1");
    chk("g1_score_l", int'(score_l), 1);
    chk("g1_playing", int'(playing), 0);
    ticks(59);
    chk("delay59_x", int'(ball_x), 628);
    do_tick();
    chk("reserve_x", int'(ball_x), XC);
    chk("reserve_y", int'(ball_y), YC);
    chk("reserve_playing", int'(playing), 1);
    do_tick();
    chk("reserve_move_x", int'(ball_x), 320);

    // 5: drive to the winning score
    ticks(60);  // undo the extra tick: wait for a fresh goal from centre
    pulse_reset();
    pulse_serve();
    for (int g = 1; g <= 9; g++) begin
      left_goal("gn");
      if (g < 9) ticks(60);
    end
    chk("win_score_l", int'(score_l), 9);
    chk("win_over", int'(game_over), 1);
    chk("win_playing", int'(playing), 0);
    ticks(5);
    chk("over_frozen_x", int'(ball_x), 628);
    pulse_serve();
    chk("restart_sl", int'(score_l), 0);
    chk("restart_x", int'(ball_x), XC);
    chk("restart_playing", int'(playing), 1);
    chk("restart_over", int'(game_over), 0);

    // 6: reset mid-play and mid-delay
    ticks(5);
    pulse_reset();
    chk_reset_vals("rst_play");
    pulse_serve();
    ticks(79);
    ticks(10);
    chk("mid_delay_sl", int'(score_l), 1);
    pulse_reset();
    chk_reset_vals("rst_scored");

    // Randomised play; paddles often track the ball to produce rallies.
    for (int c = 0; c < 20000; c++) begin
      frame_tick = ($urandom_range(0, 2) == 0);
      serve      = ($urandom_range(0, 63) == 0);
      reset      = ($urandom_range(0, 4999) == 0);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 5) == 0) paddle_l_y = 9'($urandom_range(0, 511));
        else paddle_l_y = 9'((m_y > 60) ? m_y - int'($urandom_range(0, 60)) : 0);
      end
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 5) == 0) paddle_r_y = 9'($urandom_range(0, 511));
        else paddle_r_y = 9'((m_y > 60) ? m_y - int'($urandom_range(0, 60)) : 0);
      end
      @(negedge clk);
    end
    frame_tick = 1'b0; serve = 1'b0; reset = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
- Parametrised ball and score engine for the pong game core.
- Advances the ball once per frame tick. Bounces it off the top/bottom walls and both paddles, and detects goals.
- Keeps both players' scores, runs serve delay and game-over sequencing.
- Sits between the paddle controllers and the video renderer.
- Screen size, object sizes, speeds and winning score are all set by parameters.

Parameters:
H_RES, 640, visible width in pixels
V_RES, 480, visible height in pixels
BALL_SIZE, 8, ball edge length (square)
PADDLE_W, 8, paddle width
PADDLE_H, 64, paddle height
PADDLE_X, 16, gap from screen edge to paddle outer edge
SPEED_X, 4, horizontal pixels per frame
SPEED_Y, 2, vertical pixels per frame
SERVE_DELAY, 60, frames between goal and re-serve
WIN_SCORE, 9, score that ends the game
SCORE_W, 4, score counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle pulse per frame
serve  in  1  start/restart request, level sampled each cycle
paddle_l_y  in  YW  left paddle top y (YW = $clog2(V_RES))
paddle_r_y  in  YW  right paddle top y
ball_x  out  XW  ball left x (XW = $clog2(H_RES))
ball_y  out  YW  ball top y
score_l  out  SCORE_W  left score
score_r  out  SCORE_W  right score
point_l  out  1  one-cycle pulse, left scored
point_r  out  1  one-cycle pulse, right scored
game_over  out  1  high in OVER state
playing  out  1  high in PLAY state

Behaviour:
- One clock, clk. Synchronous active-high reset; reset has priority over everything.
- Reset values:
  - state IDLE
  - ball_x = (H_RES-BALL_SIZE)/2, ball_y = (V_RES-BALL_SIZE)/2
  - dx = +SPEED_X, dy = +SPEED_Y
  - scores 0, pulses 0, game_over 0, playing 0
- All outputs are registered. Position updates are visible the cycle after the frame_tick cycle.
- States: IDLE, PLAY, SCORED, OVER.
- IDLE: ball held at centre.
  - serve=1 -> PLAY.
  - A frame_tick in the same cycle as serve does not move the ball.
- PLAY, on frame_tick, with nx = x+dx and ny = y+dy computed signed at XW+2 / YW+2 bits:
  - Vertical:
    - ny <= 0 -> y = 0, dy = +SPEED_Y.
    - ny >= V_RES-BALL_SIZE -> y = V_RES-BALL_SIZE, dy = -SPEED_Y.
    - Otherwise y = ny.
  - Left side (dx < 0):
    - Overlap test uses the current y: y+BALL_SIZE > paddle_l_y and y < paddle_l_y+PADDLE_H.
    - If nx <= PADDLE_X+PADDLE_W and overlap -> x = PADDLE_X+PADDLE_W, dx = +SPEED_X.
    - Else if nx <= 0 -> right scores.
    - Else x = nx.
  - Right side (dx > 0), with RPX = H_RES-PADDLE_X-PADDLE_W:
    - If nx+BALL_SIZE >= RPX and overlap with paddle_r_y -> x = RPX-BALL_SIZE, dx = -SPEED_X.
    - Else if nx+BALL_SIZE >= H_RES -> left scores.
    - Else x = nx.
  - The paddle check takes precedence over the goal check.
  - Vertical and horizontal updates are independent; a wall bounce and a paddle bounce on the same tick both apply.
- Goal:
  - Scorer's count increments; matching point_* pulses for exactly one cycle.
  - Ball freezes at its last in-bounds position.
  - New score == WIN_SCORE -> OVER; otherwise -> SCORED with the delay counter cleared.
- SCORED:
  - Counts frame_ticks.
  - On the SERVE_DELAY-th tick: ball recentred, dy = +SPEED_Y, dx directed toward the player who conceded, -> PLAY.
  - serve is ignored in this state.
- OVER:
  - Ball frozen, game_over = 1.
  - serve=1 -> scores cleared, ball recentred, dx = +SPEED_X, -> PLAY.
- Scores never wrap; WIN_SCORE must be < 2^SCORE_W.
- Paddle inputs are used unclamped.
- Reset mid-play or mid-delay returns everything to reset values on the next edge.

Decomposition:
- Shared package pong_pkg:
  - state enum (IDLE, PLAY, SCORED, OVER)
  - default geometry constants
  - XW/YW width helper functions
- One natural sub-module: pong_paddle_hit.
  - Combinational overlap/contact check, instantiated once per side.
- The state machine, counters and position registers stay in pong_ball_engine.

Test Plan:
1. Reset, then 10 frame_ticks with serve=0 -> ball (316,236), scores 0/0, playing=0, no movement.
2. serve pulse, then 1 frame_tick -> next cycle ball (320,238), playing=1. Bench with SPEED_Y=8: after 30 ticks ball_y=472, then next tick ball_y=464 (bottom-wall bounce).
3. paddle_r_y=350, serve, 73 ticks -> ball (608,382), dx negative. Next tick -> ball (604,384).
4. paddle_r_y=0, serve, 79 ticks -> point_l high one cycle, score_l=1, ball frozen. After 60 more frame_ticks ball (316,236) and moving right.
5. Repeat left goals to score_l=9 -> game_over=1, frame_ticks move nothing. serve -> scores 0/0, playing=1.
6. Reset asserted mid-PLAY and again mid-SCORED -> all outputs equal reset values on the following cycle.
